plic_claim: RTL

Interrupt gateway and claim/complete unit sitting between the sixteen peripheral interrupt lines and the core's external-interrupt input. It latches level requests into per-source pending bits, masks them with a CPU-writable enable register, raises a single interrupt request, and lets the trap handler claim the highest-priority source and later signal completion over the core's data bus. Fixed priority: source 0 highest, source 15 lowest.

---
 rtl/plic_claim.sv | 119 +++++++++++
 1 files changed

// File: rtl/plic_claim.sv
// plic_claim: per-source interrupt gateways with a fixed-priority claim/complete
// register interface. Source 0 has the highest priority.
module plic_claim #(
    parameter int unsigned NSRC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] int_i,
    output logic            int_o,
    input  logic            re_i,
    input  logic            we_i,
    input  logic [3:0]      addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o
);

    typedef enum logic [1:0] {
        GW_IDLE,
        GW_PENDING,
        GW_CLAIMED
    } gw_state_t;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;

    gw_state_t       state_q [NSRC];
    gw_state_t       state_d [NSRC];
    logic [NSRC-1:0] enable_q;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] eligible;
    logic [4:0]      claim_id;
    logic            claim_rd;
    logic            complete_wr;
    logic            unused_bits;

    assign unused_bits = ^{addr_i[1:0], wdata_i};

    assign claim_rd    = re_i && (addr_i[3:2] == REG_CLAIM);
    assign complete_wr = we_i && (addr_i[3:2] == REG_CLAIM);

    // Pending view of the gateways and the enabled subset that drives the core.
    always_comb begin
        pending = '0;
        for (int unsigned n = 0; n < NSRC; n++) begin
            pending[n] = (state_q[n] == GW_PENDING);
        end
        eligible = pending & enable_q;
    end

    assign int_o = |eligible;

    // Fixed-priority encoder: scan downward so the lowest eligible index wins.
    always_comb begin
        claim_id = '0;
        for (int unsigned i = NSRC; i > 0; i--) begin
            if (eligible[i-1]) begin
                claim_id = 5'(i);
            end
        end
    end

    // Gateway next-state: an ID outside 1..NSRC never matches any source,
    // which is how out-of-range completes are ignored.
    always_comb begin
        for (int unsigned n = 0; n < NSRC; n++) begin
            state_d[n] = state_q[n];
            unique case (state_q[n])
                GW_IDLE: begin
                    if (int_i[n]) state_d[n] = GW_PENDING;
                end
                GW_PENDING: begin
                    if (claim_rd && (claim_id == 5'(n + 1))) state_d[n] = GW_CLAIMED;
                end
                GW_CLAIMED: begin
                    if (complete_wr && (wdata_i[4:0] == 5'(n + 1))) state_d[n] = GW_IDLE;
                end
                default: state_d[n] = GW_IDLE;
            endcase
        end
    end

    // Gateway state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned n = 0; n < NSRC; n++) begin
                state_q[n] <= GW_IDLE;
            end
        end else begin
            for (int unsigned n = 0; n < NSRC; n++) begin
                state_q[n] <= state_d[n];
            end
        end
    end

    // ENABLE register write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q <= '0;
        end else if (we_i && (addr_i[3:2] == REG_ENABLE)) begin
            enable_q <= wdata_i[NSRC-1:0];
        end
    end

    // Registered read data, held until the next read; reflects pre-write state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_o <= '0;
        end else if (re_i) begin
            unique case (addr_i[3:2])
                REG_ENABLE:  rdata_o <= 32'(enable_q);
                REG_PENDING: rdata_o <= 32'(pending);
                REG_CLAIM:   rdata_o <= 32'(claim_id);
                default:     rdata_o <= '0;
            endcase
        end
    end

endmodule
